wb_bridge_nway: RTL

WB_BRIDGE_NWAY -- requirements
Module: wb_bridge_nway

---
 rtl/wb_bridge_pkg.sv | 22 ++
 rtl/wb_bridge_nway.sv | 124 ++++++++++++
 2 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the N-way Wishbone bridge.
// State encoding, timeout response word and a clog2 helper.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_bridge_nway.sv
// Wishbone classic 1-to-N bridge: window decode, port select, ack timeout.
// Ports: wbs_* upstream slave, wbm_* per-port master, timeout_count_o.
module wb_bridge_nway
  import wb_bridge_pkg::*;
#(
  parameter int          NUM_PORTS       = 4,
  parameter int          PORT_ADDR_WIDTH = 11,
  parameter int          SEL_LSB         = 20,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  output logic [NUM_PORTS-1:0]         wbm_stb_o,
  output logic [NUM_PORTS-1:0]         wbm_cyc_o,
  output logic                         wbm_we_o,
  output logic [3:0]                   wbm_sel_o,
  output logic [31:0]                  wbm_dat_o,
  output logic [PORT_ADDR_WIDTH-1:0]   wbm_adr_o,
  input  logic [NUM_PORTS-1:0]         wbm_ack_i,
  input  logic [NUM_PORTS*32-1:0]      wbm_dat_i,
  output logic [15:0]                  timeout_count_o
);

  localparam int SEL_W = clog2(NUM_PORTS);
  localparam int HI = SEL_LSB + SEL_W;
  localparam logic [SEL_W:0] NP_W = (SEL_W + 1)'(NUM_PORTS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [SEL_W-1:0]   port_idx;
  logic [15:0]        wait_cnt;

  logic [SEL_W-1:0]   sel_field;
  logic               hit;
  logic [NUM_PORTS-1:0] onehot;
  logic               port_ack;
  logic [31:0]        port_dat;
  logic               unused_adr;

  assign sel_field = wbs_adr_i[SEL_LSB +: SEL_W];
  assign hit = (wbs_adr_i[31:HI] == BASE_ADDR[31:HI])
            && ({1'b0, sel_field} < NP_W);
  assign onehot = NUM_PORTS'(1) << sel_field;
  assign port_ack = wbm_ack_i[port_idx];
  assign port_dat = wbm_dat_i[{port_idx, 5'd0} +: 32];
  // Address bits between the port field and the window field are don't-care.
  assign unused_adr = ^wbs_adr_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state           <= IDLE;
      port_idx        <= '0;
      wait_cnt        <= '0;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
      wbm_stb_o       <= '0;
      wbm_cyc_o       <= '0;
      wbm_we_o        <= 1'b0;
      wbm_sel_o       <= '0;
      wbm_dat_o       <= '0;
      wbm_adr_o       <= '0;
      timeout_count_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            if (hit) begin
              port_idx  <= sel_field;
              wbm_we_o  <= wbs_we_i;
              wbm_sel_o <= wbs_sel_i;
              wbm_dat_o <= wbs_dat_i;
              wbm_adr_o <= wbs_adr_i[PORT_ADDR_WIDTH-1:0];
              wbm_stb_o <= onehot;
              wbm_cyc_o <= onehot;
              wait_cnt  <= '0;
              state     <= BUSY;
            end else begin
              wbs_dat_o <= '0;
              wbs_ack_o <= 1'b1;
              state     <= RESP;
            end
          end
        end
        BUSY: begin
          // Abort beats ack; ack beats timeout.
          if (!wbs_cyc_i) begin
            wbm_stb_o <= '0;
            wbm_cyc_o <= '0;
            state     <= IDLE;
          end else if (port_ack) begin
            wbs_dat_o <= port_dat;
            wbs_ack_o <= 1'b1;
            wbm_stb_o <= '0;
            wbm_cyc_o <= '0;
            state     <= RESP;
          end else if (wait_cnt == TO_LAST) begin
            wbs_dat_o <= TIMEOUT_DATA;
            wbs_ack_o <= 1'b1;
            wbm_stb_o <= '0;
            wbm_cyc_o <= '0;
            if (timeout_count_o != 16'hFFFF)
              timeout_count_o <= timeout_count_o + 16'd1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
